// File: rtl/spi_master.sv
// spi_master: single-byte SPI master. Shifts tx_data_i out MSB-first on mosi_o,
// captures miso_i into rx_data_o, and drives one active-high slave select.
// sck_o idles low and has a half-period of CLK_DIV Clk_i cycles.
// Ports:
//   Clk_i, Rst_i        clock, synchronous active-high reset
//   start_i, tx_data_i, slave_sel_i   transfer request (sampled together)
//   rx_data_o, busy_o, done_o, err_o  status toward the local controller
//   sck_o, mosi_o, miso_i, ss_o       SPI bus
module spi_master #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SS_GAP     = 4,
  localparam int unsigned SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  Clk_i,
  input  logic                  Rst_i,
  input  logic                  start_i,
  input  logic [7:0]            tx_data_i,
  input  logic [SEL_W-1:0]      slave_sel_i,
  output logic [7:0]            rx_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  sck_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic [NUM_SLAVES-1:0] ss_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned GAP_W = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t                state, state_d;
  logic [DIV_W-1:0]      div, div_d;
  logic [GAP_W-1:0]      gap_cnt, gap_d;
  logic [3:0]            bitcnt, bitcnt_d;
  logic [7:0]            tx_sh, tx_d;
  logic [7:0]            rx_sh, rx_sh_d;
  logic [7:0]            rx_data_d;
  logic [NUM_SLAVES-1:0] ss_d;
  logic                  sck_d, mosi_d, busy_d, done_d, err_d;
  logic                  miso_q, miso_s;
  logic                  div_end, sel_ok;

  assign div_end = (div == DIV_W'(CLK_DIV - 1));
  assign sel_ok  = (32'(slave_sel_i) < NUM_SLAVES);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    div_d     = div;
    gap_d     = gap_cnt;
    bitcnt_d  = bitcnt;
    tx_d      = tx_sh;
    rx_sh_d   = rx_sh;
    rx_data_d = rx_data_o;
    ss_d      = ss_o;
    sck_d     = sck_o;
    mosi_d    = mosi_o;
    busy_d    = busy_o;
    done_d    = 1'b0;
    err_d     = 1'b0;

    // Divider free-runs in every bus-active state; each such state lasts one divider lap
    if (state != IDLE && state != GAP) begin
      div_d = div_end ? '0 : div + DIV_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (start_i) begin
          if (sel_ok) begin
            tx_d     = tx_data_i;
            ss_d     = NUM_SLAVES'(1) << slave_sel_i;
            busy_d   = 1'b1;
            mosi_d   = tx_data_i[7];
            bitcnt_d = 4'd0;
            div_d    = '0;
            state_d  = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // Rising sck edge: sample synchronised miso; the slave updates its output well after this
      SETUP, LOW: begin
        if (div_end) begin
          sck_d    = 1'b1;
          rx_sh_d  = {rx_sh[6:0], miso_s};
          bitcnt_d = bitcnt + 4'd1;
          state_d  = HIGH;
        end
      end
      // Falling sck edge: present the next bit unless all eight have been clocked
      HIGH: begin
        if (div_end) begin
          sck_d = 1'b0;
          if (bitcnt == 4'd8) begin
            state_d = HOLD;
          end else begin
            tx_d    = {tx_sh[6:0], 1'b0};
            mosi_d  = tx_sh[6];
            state_d = LOW;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          ss_d      = '0;
          mosi_d    = 1'b0;
          rx_data_d = rx_sh;
          done_d    = 1'b1;
          gap_d     = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(SS_GAP - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_cnt + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; miso passes a 2-FF synchroniser
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state     <= IDLE;
      div       <= '0;
      gap_cnt   <= '0;
      bitcnt    <= 4'd0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      rx_data_o <= 8'h00;
      ss_o      <= '0;
      sck_o     <= 1'b0;
      mosi_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      miso_q    <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      state     <= state_d;
      div       <= div_d;
      gap_cnt   <= gap_d;
      bitcnt    <= bitcnt_d;
      tx_sh     <= tx_d;
      rx_sh     <= rx_sh_d;
      rx_data_o <= rx_data_d;
      ss_o      <= ss_d;
      sck_o     <= sck_d;
      mosi_o    <= mosi_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      err_o     <= err_d;
      miso_q    <= miso_i;
      miso_s    <= miso_q;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: bench for spi_master. Two instances: dut0 (4 slaves, CLK_DIV=4,
// SS_GAP=4) exercised with loopback and a behavioural slave, dut1 (3 slaves,
// CLK_DIV=6, SS_GAP=2) for the slow-clock and invalid-select cases.
// Expected bus activity is computed from the transfer's cycle offset since start.
module tb_spi_master;

  localparam int N0 = 4, D0 = 4, G0 = 4;
  localparam int N1 = 3, D1 = 6, G1 = 2;

  logic       Clk, Rst;
  logic       start0, busy0, done0, err0, sck0, mosi0, miso0, loop0;
  logic [7:0] tx0, rx0;
  logic [1:0] sel0;
  logic [3:0] ss0;
  logic       start1, busy1, done1, err1, sck1, mosi1, miso1;
  logic [7:0] tx1, rx1;
  logic [1:0] sel1;
  logic [2:0] ss1;

  int checks = 0, failures = 0, cyc = 0;

  // Behavioural slave (select index 2 of dut0)
  logic [7:0] sl_xmit, sl_sh, sl_rcvd_sh, sl_rcvd;
  logic       sl_act, sl_sck_q, sl_miso;
  int         sl_ready_cnt;

  // Reference model state
  bit         m0_on, m1_on, m0_err, m1_err;
  int         m0_k, m1_k, m0_sel, m1_sel;
  logic [7:0] m0_tx, m0_rx, m0_rxnew, m1_tx, m1_rx, m1_rxnew;

  // Bus measurements
  int   len0, rise0, last_len0, last_rise0, done_cnt0, err_cnt0, done_cyc0, bfall_cyc0;
  int   len1, rise1, last_len1, last_rise1, done_cnt1, err_cnt1, done_cyc1, bfall_cyc1;
  int   rise_cyc1, period1;
  logic sck_q0, busy_q0, sck_q1, busy_q1;

  assign miso0 = loop0 ? mosi0 : sl_miso;
  assign miso1 = mosi1;

  spi_master #(.NUM_SLAVES(N0), .CLK_DIV(D0), .SS_GAP(G0)) dut0 (
    .Clk_i(Clk), .Rst_i(Rst), .start_i(start0), .tx_data_i(tx0), .slave_sel_i(sel0),
    .rx_data_o(rx0), .busy_o(busy0), .done_o(done0), .err_o(err0),
    .sck_o(sck0), .mosi_o(mosi0), .miso_i(miso0), .ss_o(ss0)
  );

  spi_master #(.NUM_SLAVES(N1), .CLK_DIV(D1), .SS_GAP(G1)) dut1 (
    .Clk_i(Clk), .Rst_i(Rst), .start_i(start1), .tx_data_i(tx1), .slave_sel_i(sel1),
    .rx_data_o(rx1), .busy_o(busy1), .done_o(done1), .err_o(err1),
    .sck_o(sck1), .mosi_o(mosi1), .miso_i(miso1), .ss_o(ss1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Slave: present MSB while selected, capture mosi on sck rise, shift on sck fall
  initial begin
    sl_sh = 8'h00; sl_rcvd_sh = 8'h00; sl_rcvd = 8'h00;
    sl_act = 1'b0; sl_sck_q = 1'b0; sl_miso = 1'b0; sl_ready_cnt = 0;
  end
  always @(negedge Clk) begin
    if (ss0[2]) begin
      if (!sl_act) begin
        sl_act = 1'b1;
        sl_sh  = sl_xmit;
      end
      if (sck0 && !sl_sck_q) sl_rcvd_sh = {sl_rcvd_sh[6:0], mosi0};
      if (!sck0 && sl_sck_q) sl_sh = {sl_sh[6:0], 1'b0};
    end else if (sl_act) begin
      sl_act  = 1'b0;
      sl_rcvd = sl_rcvd_sh;
      sl_ready_cnt++;
    end
    sl_sck_q = sck0;
    sl_miso  = sl_sh[7];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus levels k cycles after an accepted start: 17 half-periods with ss high
  // (SETUP, then alternating HIGH/LOW, HOLD), then done, then the gap.
  task automatic expect_out(input int k, input int d, input int g, input logic [7:0] tx,
                            input int sel, output logic [31:0] ss, output logic sck,
                            output logic mosi, output logic busy, output logic done);
    int p, b;
    ss = '0; sck = 1'b0; mosi = 1'b0; busy = 1'b0; done = 1'b0;
    if (k > 0) begin
      busy = (k <= 17 * d + g);
      done = (k == 17 * d + 1);
      if (k <= 17 * d) begin
        p    = (k - 1) / d;
        b    = (p / 2 > 7) ? 0 : 7 - p / 2;
        ss   = 32'd1 << sel;
        sck  = p[0];
        mosi = tx[b];
      end
    end
  endtask

  task automatic run_model();
    logic [31:0] e_ss;
    logic        e_sck, e_mosi, e_busy, e_done;
    forever begin
      @(negedge Clk);
      cyc++;
      if (m0_on) begin
        expect_out(m0_k, D0, G0, m0_tx, m0_sel, e_ss, e_sck, e_mosi, e_busy, e_done);
        chk("dut0.ss", 32'(ss0), e_ss);
        chk("dut0.sck", 32'(sck0), 32'(e_sck));
        chk("dut0.mosi", 32'(mosi0), 32'(e_mosi));
        chk("dut0.busy", 32'(busy0), 32'(e_busy));
        chk("dut0.done", 32'(done0), 32'(e_done));
        chk("dut0.err", 32'(err0), 32'(m0_err));
        chk("dut0.rx", 32'(rx0), 32'(m0_rx));
      end
      if (m1_on) begin
        expect_out(m1_k, D1, G1, m1_tx, m1_sel, e_ss, e_sck, e_mosi, e_busy, e_done);
        chk("dut1.ss", 32'(ss1), e_ss);
        chk("dut1.sck", 32'(sck1), 32'(e_sck));
        chk("dut1.mosi", 32'(mosi1), 32'(e_mosi));
        chk("dut1.busy", 32'(busy1), 32'(e_busy));
        chk("dut1.done", 32'(done1), 32'(e_done));
        chk("dut1.err", 32'(err1), 32'(m1_err));
        chk("dut1.rx", 32'(rx1), 32'(m1_rx));
      end

      if (ss0 != '0) begin
        len0++;
        if (sck0 && !sck_q0) rise0++;
      end else if (len0 != 0) begin
        last_len0 = len0; last_rise0 = rise0; len0 = 0; rise0 = 0;
      end
      if (done0) begin done_cnt0++; done_cyc0 = cyc; end
      if (err0) err_cnt0++;
      if (busy_q0 && !busy0) bfall_cyc0 = cyc;
      sck_q0 = sck0; busy_q0 = busy0;

      if (ss1 != '0) begin
        len1++;
        if (sck1 && !sck_q1) rise1++;
      end else if (len1 != 0) begin
        last_len1 = len1; last_rise1 = rise1; len1 = 0; rise1 = 0;
      end
      if (sck1 && !sck_q1) begin period1 = cyc - rise_cyc1; rise_cyc1 = cyc; end
      if (done1) begin done_cnt1++; done_cyc1 = cyc; end
      if (err1) err_cnt1++;
      if (busy_q1 && !busy1) bfall_cyc1 = cyc;
      sck_q1 = sck1; busy_q1 = busy1;

      // Advance the model to the next cycle using the inputs seen at the coming edge
      m0_err = 1'b0;
      m1_err = 1'b0;
      if (Rst) begin
        m0_on = 1'b1; m0_k = 0; m0_rx = 8'h00;
        m1_on = 1'b1; m1_k = 0; m1_rx = 8'h00;
      end else begin
        if (m0_k == 0) begin
          if (start0) begin
            if (int'(sel0) < N0) begin
              m0_k = 1; m0_tx = tx0; m0_sel = int'(sel0);
              m0_rxnew = loop0 ? tx0 : sl_xmit;
            end else m0_err = 1'b1;
          end
        end else begin
          m0_k++;
          if (m0_k == 17 * D0 + 1) m0_rx = m0_rxnew;
          if (m0_k > 17 * D0 + G0) m0_k = 0;
        end
        if (m1_k == 0) begin
          if (start1) begin
            if (int'(sel1) < N1) begin
              m1_k = 1; m1_tx = tx1; m1_sel = int'(sel1); m1_rxnew = tx1;
            end else m1_err = 1'b1;
          end
        end else begin
          m1_k++;
          if (m1_k == 17 * D1 + 1) m1_rx = m1_rxnew;
          if (m1_k > 17 * D1 + G1) m1_k = 0;
        end
      end
    end
  endtask

  task automatic pulse0(input logic [7:0] tx, input logic [1:0] sel);
    start0 = 1'b1; tx0 = tx; sel0 = sel;
    @(posedge Clk); #2;
    start0 = 1'b0;
  endtask

  task automatic pulse1(input logic [7:0] tx, input logic [1:0] sel);
    start1 = 1'b1; tx1 = tx; sel1 = sel;
    @(posedge Clk); #2;
    start1 = 1'b0;
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 400) begin @(posedge Clk); #2; n++; end
    chk("dut0.idle_within_budget", 32'(busy0), 0);
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (busy1 && n < 400) begin @(posedge Clk); #2; n++; end
    chk("dut1.idle_within_budget", 32'(busy1), 0);
  endtask

  initial begin
    int n;
    Rst = 1'b1; loop0 = 1'b1; sl_xmit = 8'h00;
    start0 = 1'b0; tx0 = 8'h00; sel0 = 2'd0;
    start1 = 1'b0; tx1 = 8'h00; sel1 = 2'd0;
    m0_on = 1'b0; m1_on = 1'b0; m0_k = 0; m1_k = 0; m0_err = 1'b0; m1_err = 1'b0;
    m0_rx = 8'h00; m1_rx = 8'h00; m0_tx = 8'h00; m1_tx = 8'h00; m0_sel = 0; m1_sel = 0;
    m0_rxnew = 8'h00; m1_rxnew = 8'h00;
    len0 = 0; rise0 = 0; last_len0 = 0; last_rise0 = 0; done_cnt0 = 0; err_cnt0 = 0;
    len1 = 0; rise1 = 0; last_len1 = 0; last_rise1 = 0; done_cnt1 = 0; err_cnt1 = 0;
    done_cyc0 = 0; bfall_cyc0 = 0; done_cyc1 = 0; bfall_cyc1 = 0; rise_cyc1 = 0; period1 = 0;
    sck_q0 = 1'b0; busy_q0 = 1'b0; sck_q1 = 1'b0; busy_q1 = 1'b0;
    fork
      run_model();
    join_none

    repeat (3) @(posedge Clk);
    #2;
    Rst = 1'b0;
    chk("reset.ss0", 32'(ss0), 0);
    chk("reset.sck0", 32'(sck0), 0);
    chk("reset.busy0", 32'(busy0), 0);
    chk("reset.rx0", 32'(rx0), 0);
    chk("reset.ss1", 32'(ss1), 0);

    // Loopback A5 to slave 1
    pulse0(8'hA5, 2'd1);
    chk("t1.ss_first", 32'(ss0), 32'h2);
    chk("t1.mosi_first", 32'(mosi0), 1);
    chk("t1.busy_first", 32'(busy0), 1);
    wait_idle0();
    chk("t1.rx", 32'(rx0), 32'hA5);
    chk("t1.ss_len", 32'(last_len0), 68);
    chk("t1.sck_rises", 32'(last_rise0), 8);
    chk("t1.done_count", 32'(done_cnt0), 1);

    // Full duplex with the slave model at index 2
    loop0 = 1'b0; sl_xmit = 8'h3C;
    pulse0(8'hC3, 2'd2);
    wait_idle0();
    chk("t2.slave_rcvd", 32'(sl_rcvd), 32'hC3);
    chk("t2.slave_ready", 32'(sl_ready_cnt), 1);
    chk("t2.rx", 32'(rx0), 32'h3C);
    loop0 = 1'b1;

    // Starts during SETUP and HOLD are ignored; back-to-back start on first idle cycle
    pulse0(8'h01, 2'd3);
    @(posedge Clk); #2;
    pulse0(8'hEE, 2'd1);
    repeat (62) @(posedge Clk);
    #2;
    chk("t3.in_hold_ss", 32'(ss0), 32'h8);
    chk("t3.in_hold_sck", 32'(sck0), 0);
    pulse0(8'hFF, 2'd0);
    wait_idle0();
    chk("t3.rx_first", 32'(rx0), 32'h01);
    pulse0(8'h80, 2'd2);
    chk("t3.b2b_busy", 32'(busy0), 1);
    chk("t3.b2b_ss", 32'(ss0), 32'h4);
    chk("t3.busy_fall_after_done", 32'(bfall_cyc0 - done_cyc0), G0);
    wait_idle0();
    chk("t3.rx_second", 32'(rx0), 32'h80);
    chk("t3.done_count", 32'(done_cnt0), 4);

    // Reset after the third sck rise aborts without done
    pulse0(8'hE7, 2'd0);
    n = 0;
    while (rise0 < 3 && n < 200) begin @(posedge Clk); #2; n++; end
    chk("t5.third_rise_seen", 32'(rise0 >= 3), 1);
    Rst = 1'b1;
    @(posedge Clk); #2;
    Rst = 1'b0;
    chk("t5.ss_after_rst", 32'(ss0), 0);
    chk("t5.sck_after_rst", 32'(sck0), 0);
    chk("t5.busy_after_rst", 32'(busy0), 0);
    chk("t5.mosi_after_rst", 32'(mosi0), 0);
    chk("t5.rx_after_rst", 32'(rx0), 0);
    pulse0(8'h5A, 2'd1);
    wait_idle0();
    chk("t5.rx", 32'(rx0), 32'h5A);
    chk("t5.done_count", 32'(done_cnt0), 5);

    // Slow divider instance: loopback FF then 00
    pulse1(8'hFF, 2'd0);
    wait_idle1();
    chk("t6.rx_ff", 32'(rx1), 32'hFF);
    chk("t6.ss_len", 32'(last_len1), 102);
    chk("t6.sck_rises", 32'(last_rise1), 8);
    chk("t6.sck_period", 32'(period1), 12);
    pulse1(8'h00, 2'd2);
    chk("t6.busy_fall_after_done", 32'(bfall_cyc1 - done_cyc1), G1);
    wait_idle1();
    chk("t6.rx_00", 32'(rx1), 32'h00);

    // Invalid select while idle pulses err; while busy it is ignored
    pulse1(8'h77, 2'd3);
    chk("t4.err_pulse", 32'(err1), 1);
    chk("t4.ss_stays_0", 32'(ss1), 0);
    chk("t4.busy_stays_0", 32'(busy1), 0);
    @(posedge Clk); #2;
    chk("t4.err_one_cycle", 32'(err1), 0);
    chk("t4.rx_unchanged", 32'(rx1), 32'h00);
    pulse1(8'h11, 2'd1);
    pulse1(8'h22, 2'd3);
    wait_idle1();
    chk("t4.err_count", 32'(err_cnt1), 1);
    chk("t4.rx_after_ignore", 32'(rx1), 32'h11);
    chk("t4.dut0_no_err", 32'(err_cnt0), 0);

    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
